// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: handshake, decode and status signals between the sequencer and the core/memories
interface multicycle_ctrl_if #(parameter int CNT_W = 32);
  logic [6:0] opcode;
  logic alu_zero;
  logic [2:0] funct3;
  logic imem_ready;
  logic dmem_ready;
  logic imem_req;
  logic dmem_req;
  logic ir_write;
  logic pc_write;
  logic pc_src;
  logic reg_write;
  logic mem2reg;
  logic alu_src;
  logic mem_read;
  logic mem_write;
  logic [1:0] alu_op;
  logic trap;
  logic [1:0] trap_cause;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] instret_cnt;
  modport master (
    input opcode, alu_zero, funct3, imem_ready, dmem_ready,
    output imem_req, dmem_req, ir_write, pc_write, pc_src, reg_write, mem2reg,
    alu_src, mem_read, mem_write, alu_op, trap, trap_cause, cycle_cnt, instret_cnt
  );
  modport slave (
    output opcode, alu_zero, funct3, imem_ready, dmem_ready,
    input imem_req, dmem_req, ir_write, pc_write, pc_src, reg_write, mem2reg,
    alu_src, mem_read, mem_write, alu_op, trap, trap_cause, cycle_cnt, instret_cnt
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: RV32 multi-cycle sequencer with memory handshakes, traps and optional perf counters (PERF_CNT_EN)
module multicycle_ctrl #(
  parameter int CNT_W = 32,
  parameter int MAX_WAIT = 15
) (
  input logic clk,
  input logic reset,
  multicycle_ctrl_if.master bus
);
  localparam int WW = MAX_WAIT > 0 ? $clog2(MAX_WAIT + 1) : 1;
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;
  state_t state, nxt;
  logic [1:0] cause, cause_nxt;
  logic [WW-1:0] wait_cnt;
  logic is_r, is_i, is_lw, is_sw, is_br, legal, taken, req, rdy, timeout;
  assign is_r = bus.opcode == 7'b0110011;
  assign is_i = bus.opcode == 7'b0010011;
  assign is_lw = bus.opcode == 7'b0000011;
  assign is_sw = bus.opcode == 7'b0100011;
  assign is_br = bus.opcode == 7'b1100011;
  assign legal = is_r | is_i | is_lw | is_sw | is_br;
  assign taken = is_br & ((bus.funct3 == 3'b000 & bus.alu_zero) | (bus.funct3 == 3'b001 & ~bus.alu_zero));
  assign req = state == FETCH || state == MEM;
  assign rdy = state == FETCH ? bus.imem_ready : bus.dmem_ready;
  assign timeout = MAX_WAIT > 0 && req && !rdy && wait_cnt == WW'(MAX_WAIT);
  // state, trap cause and per-request wait counter; wait count restarts on every state change
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
      cause <= 2'b00;
      wait_cnt <= '0;
    end else begin
      state <= nxt;
      cause <= cause_nxt;
      wait_cnt <= nxt != state ? '0 : (req && !rdy) ? wait_cnt + 1'b1 : wait_cnt;
    end
  end
  // next state and control outputs, all forced low while reset is asserted
  always_comb begin
    nxt = state;
    cause_nxt = cause;
    bus.imem_req = 1'b0;
    bus.dmem_req = 1'b0;
    bus.ir_write = 1'b0;
    bus.pc_write = 1'b0;
    bus.pc_src = 1'b0;
    bus.reg_write = 1'b0;
    bus.mem2reg = 1'b0;
    bus.alu_src = 1'b0;
    bus.mem_read = 1'b0;
    bus.mem_write = 1'b0;
    bus.alu_op = 2'b00;
    bus.trap = 1'b0;
    bus.trap_cause = 2'b00;
    if (!reset)
      case (state)
        FETCH: begin
          bus.imem_req = 1'b1;
          bus.ir_write = bus.imem_ready;
          bus.pc_write = bus.imem_ready;
          nxt = bus.imem_ready ? DECODE : timeout ? TRAP : FETCH;
          cause_nxt = timeout ? 2'b10 : cause;
        end
        DECODE: begin
          nxt = legal ? EXEC : TRAP;
          cause_nxt = legal ? cause : 2'b01;
        end
        EXEC: begin
          bus.alu_src = is_i | is_lw | is_sw;
          bus.alu_op = is_br ? 2'b01 : (is_lw | is_sw) ? 2'b00 : 2'b10;
          bus.pc_write = taken;
          bus.pc_src = taken;
          nxt = is_br ? FETCH : (is_lw | is_sw) ? MEM : WB;
        end
        MEM: begin
          bus.dmem_req = 1'b1;
          bus.mem_read = is_lw;
          bus.mem_write = is_sw;
          nxt = bus.dmem_ready ? (is_lw ? WB : FETCH) : timeout ? TRAP : MEM;
          cause_nxt = timeout ? 2'b11 : cause;
        end
        WB: begin
          bus.reg_write = 1'b1;
          bus.mem2reg = is_lw;
          nxt = FETCH;
        end
        TRAP: begin
          bus.trap = 1'b1;
          bus.trap_cause = cause;
        end
        default: nxt = FETCH;
      endcase
  end
`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] cyc, ret;
  logic retire;
  assign retire = nxt == FETCH && (state == EXEC || state == MEM || state == WB);
  // free-running cycle count and retired-instruction count, both wrapping
  always_ff @(posedge clk) begin
    if (reset) begin
      cyc <= '0;
      ret <= '0;
    end else begin
      cyc <= cyc + 1'b1;
      ret <= retire ? ret + 1'b1 : ret;
    end
  end
  assign bus.cycle_cnt = reset ? '0 : cyc;
  assign bus.instret_cnt = reset ? '0 : ret;
`else
  assign bus.cycle_cnt = '0;
  assign bus.instret_cnt = '0;
`endif
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed instruction sequences checked every cycle against a phase-plan model
module tb_multicycle_ctrl;
  typedef struct packed {
    logic imem_req, dmem_req, ir_write, pc_write, pc_src, reg_write, mem2reg, alu_src, mem_read, mem_write;
    logic [1:0] alu_op;
    logic trap;
    logic [1:0] trap_cause;
  } ov_t;
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011, OP_BR = 7'b1100011, OP_BAD = 7'b1111111;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int errors = 0;
  int checks = 0;
  ov_t exp_v = '0;
  ov_t act;
  logic exp_valid = 1'b0;
  string exp_name = "idle";
  int exp_cyc = 0;
  int exp_ret = 0;
  always #5 clk = ~clk;
  multicycle_ctrl_if #(.CNT_W(32)) bus();
  multicycle_ctrl #(.CNT_W(32), .MAX_WAIT(15)) dut (.clk(clk), .reset(reset), .bus(bus));
  assign act = {bus.imem_req, bus.dmem_req, bus.ir_write, bus.pc_write, bus.pc_src, bus.reg_write,
                bus.mem2reg, bus.alu_src, bus.mem_read, bus.mem_write, bus.alu_op, bus.trap, bus.trap_cause};
  function automatic logic legal(input logic [6:0] op);
    return op inside {OP_R, OP_I, OP_LW, OP_SW, OP_BR};
  endfunction
  function automatic ov_t v_f(input logic rdy);
    ov_t v = '0;
    v.imem_req = 1'b1;
    v.ir_write = rdy;
    v.pc_write = rdy;
    return v;
  endfunction
  function automatic ov_t v_e(input logic [6:0] op, input logic [2:0] f3, input logic z);
    ov_t v = '0;
    logic tk;
    tk = op == OP_BR && ((f3 == 3'b000 && z) || (f3 == 3'b001 && !z));
    v.alu_src = op == OP_I || op == OP_LW || op == OP_SW;
    v.alu_op = op == OP_BR ? 2'b01 : (op == OP_LW || op == OP_SW) ? 2'b00 : 2'b10;
    v.pc_write = tk;
    v.pc_src = tk;
    return v;
  endfunction
  function automatic ov_t v_m(input logic [6:0] op);
    ov_t v = '0;
    v.dmem_req = 1'b1;
    v.mem_read = op == OP_LW;
    v.mem_write = op == OP_SW;
    return v;
  endfunction
  function automatic ov_t v_w(input logic [6:0] op);
    ov_t v = '0;
    v.reg_write = 1'b1;
    v.mem2reg = op == OP_LW;
    return v;
  endfunction
  function automatic ov_t v_t(input logic [1:0] c);
    ov_t v = '0;
    v.trap = 1'b1;
    v.trap_cause = c;
    return v;
  endfunction
  // per-cycle comparison of control outputs and counters against the expectation for this cycle
  always @(negedge clk) begin
    logic [31:0] ec, er;
    if (exp_valid) begin
      checks++;
      if (act !== exp_v) begin
        errors++;
        $display("FAIL %s ctrl: got %h want %h", exp_name, act, exp_v);
      end
`ifdef PERF_CNT_EN
      ec = reset ? 32'd0 : 32'(exp_cyc);
      er = reset ? 32'd0 : 32'(exp_ret);
`else
      ec = 32'd0;
      er = 32'd0;
`endif
      checks++;
      if (bus.cycle_cnt !== ec || bus.instret_cnt !== er) begin
        errors++;
        $display("FAIL %s cnt: got cyc=%0d ret=%0d want cyc=%0d ret=%0d", exp_name, bus.cycle_cnt, bus.instret_cnt, ec, er);
      end
    end
  end
  task automatic step(input string nm, input ov_t v);
    exp_name = nm;
    exp_v = v;
    exp_valid = 1'b1;
    @(posedge clk);
    #1;
    exp_cyc++;
  endtask
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask
  task automatic do_reset();
    reset = 1'b1;
    bus.imem_ready = 1'b1;
    bus.dmem_ready = 1'b1;
    step("rst", '0);
    step("rst", '0);
    reset = 1'b0;
    bus.imem_ready = 1'b0;
    bus.dmem_ready = 1'b0;
    exp_cyc = 0;
    exp_ret = 0;
  endtask
  task automatic run(input string nm, input logic [6:0] op, input logic [2:0] f3, input logic z, input int iw, input int dw);
    bus.opcode = op;
    bus.funct3 = f3;
    bus.alu_zero = z;
    bus.dmem_ready = 1'b0;
    for (int i = 0; i < iw; i++) begin
      bus.imem_ready = 1'b0;
      step({nm, ".F"}, v_f(1'b0));
    end
    bus.imem_ready = 1'b1;
    step({nm, ".F"}, v_f(1'b1));
    bus.dmem_ready = 1'b1;
    step({nm, ".D"}, '0);
    if (!legal(op)) begin
      for (int i = 0; i < 20; i++) step({nm, ".T"}, v_t(2'b01));
      return;
    end
    step({nm, ".E"}, v_e(op, f3, z));
    bus.imem_ready = 1'b0;
    bus.dmem_ready = 1'b0;
    if (op == OP_BR) begin
      exp_ret++;
      return;
    end
    if (op == OP_LW || op == OP_SW) begin
      for (int j = 0; j < dw; j++) step({nm, ".M"}, v_m(op));
      bus.dmem_ready = 1'b1;
      step({nm, ".M"}, v_m(op));
      bus.dmem_ready = 1'b0;
      if (op == OP_SW) begin
        exp_ret++;
        return;
      end
    end
    step({nm, ".W"}, v_w(op));
    exp_ret++;
  endtask
  initial begin
    bus.opcode = OP_R;
    bus.funct3 = 3'b000;
    bus.alu_zero = 1'b0;
    bus.imem_ready = 1'b0;
    bus.dmem_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("pin.f", {17'd0, v_f(1'b1)}, 32'h5800);
    chk("pin.e_beq", {17'd0, v_e(OP_BR, 3'b000, 1'b1)}, 32'h0C08);
    chk("pin.e_i", {17'd0, v_e(OP_I, 3'b000, 1'b0)}, 32'h0090);
    chk("pin.m_sw", {17'd0, v_m(OP_SW)}, 32'h2020);
    chk("pin.w_lw", {17'd0, v_w(OP_LW)}, 32'h0300);
    chk("pin.t", {17'd0, v_t(2'b01)}, 32'h0005);
    do_reset();
    run("r0", OP_R, 3'b000, 1'b0, 0, 0);
    chk("r0.next_req", {31'd0, bus.imem_req}, 32'd1);
    run("i2", OP_I, 3'b000, 1'b0, 2, 0);
    run("lw3", OP_LW, 3'b010, 1'b0, 0, 3);
    run("sw0", OP_SW, 3'b010, 1'b0, 1, 0);
    run("beq_t", OP_BR, 3'b000, 1'b1, 0, 0);
    run("bne_n", OP_BR, 3'b001, 1'b1, 0, 0);
    run("bne_t", OP_BR, 3'b001, 1'b0, 0, 0);
    run("beq_n", OP_BR, 3'b000, 1'b0, 0, 0);
    run("blt_n", OP_BR, 3'b100, 1'b1, 0, 0);
    run("r_w15", OP_R, 3'b000, 1'b0, 15, 0);
    run("lw_w15", OP_LW, 3'b010, 1'b0, 0, 15);
    run("sw_b", OP_SW, 3'b010, 1'b0, 0, 0);
    bus.opcode = OP_SW;
    bus.imem_ready = 1'b1;
    step("swrst.F", v_f(1'b1));
    bus.imem_ready = 1'b0;
    step("swrst.D", '0);
    step("swrst.E", v_e(OP_SW, 3'b010, 1'b0));
    step("swrst.M", v_m(OP_SW));
    step("swrst.M", v_m(OP_SW));
    reset = 1'b1;
    step("swrst.R", '0);
    reset = 1'b0;
    exp_cyc = 0;
    exp_ret = 0;
    chk("swrst.mem_write", {31'd0, bus.mem_write}, 32'd0);
    step("swrst.F2", v_f(1'b0));
    run("after_rst", OP_I, 3'b000, 1'b0, 0, 0);
    do_reset();
    bus.opcode = OP_R;
    for (int i = 0; i < 16; i++) step("to_i.F", v_f(1'b0));
    bus.imem_ready = 1'b1;
    for (int i = 0; i < 5; i++) step("to_i.T", v_t(2'b10));
    chk("to_i.cause", {30'd0, bus.trap_cause}, 32'd2);
    chk("to_i.req", {31'd0, bus.imem_req}, 32'd0);
    do_reset();
    bus.opcode = OP_LW;
    bus.imem_ready = 1'b1;
    step("to_d.F", v_f(1'b1));
    bus.imem_ready = 1'b0;
    step("to_d.D", '0);
    step("to_d.E", v_e(OP_LW, 3'b010, 1'b0));
    for (int i = 0; i < 16; i++) step("to_d.M", v_m(OP_LW));
    bus.dmem_ready = 1'b1;
    for (int i = 0; i < 3; i++) step("to_d.T", v_t(2'b11));
    chk("to_d.cause", {30'd0, bus.trap_cause}, 32'd3);
    do_reset();
    run("bad", OP_BAD, 3'b000, 1'b0, 0, 0);
    chk("bad.trap", {31'd0, bus.trap}, 32'd1);
    chk("bad.cause", {30'd0, bus.trap_cause}, 32'd1);
    chk("bad.req", {31'd0, bus.imem_req}, 32'd0);
    do_reset();
    run("final", OP_R, 3'b000, 1'b0, 0, 0);
    exp_valid = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
